// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types for the pipeline hazard controller.
//   state_t : controller state (RUN, MEM_WAIT)
//   cause_t : reason the pipeline is not advancing normally this cycle
//   RWIDTH_DEF / CWIDTH_DEF : default register-index and counter widths
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int RWIDTH_DEF = 4;
   localparam int CWIDTH_DEF = 16;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   typedef enum logic [2:0] {
      CAUSE_NONE     = 3'd0,
      CAUSE_MEM      = 3'd1,
      CAUSE_BRANCH   = 3'd2,
      CAUSE_LOAD_USE = 3'd3,
      CAUSE_IMEM     = 3'd4
   } cause_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the hazard controller and the pipeline datapath.
//   Hazard inputs : id_rs1/rs2 + use flags, ex_rd/is_load/reg_we, br_taken,
//                   imem_valid, mem_req, mem_ack
//   Control out   : pc_en, f_en/f_flush, d_en/d_flush, e_en, m_en
//   Status out    : stall_cnt, flush_cnt, mem_timeout
// modport master : the hazard controller
// modport slave  : the pipeline datapath
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
   parameter int RWIDTH = pipe_ctrl_pkg::RWIDTH_DEF,
   parameter int CWIDTH = pipe_ctrl_pkg::CWIDTH_DEF
) ();

   logic [RWIDTH-1:0] id_rs1_i;
   logic [RWIDTH-1:0] id_rs2_i;
   logic              id_use_rs1_i;
   logic              id_use_rs2_i;
   logic [RWIDTH-1:0] ex_rd_i;
   logic              ex_is_load_i;
   logic              ex_reg_we_i;
   logic              br_taken_i;
   logic              imem_valid_i;
   logic              mem_req_i;
   logic              mem_ack_i;

   logic              pc_en_o;
   logic              f_en_o;
   logic              f_flush_o;
   logic              d_en_o;
   logic              d_flush_o;
   logic              e_en_o;
   logic              m_en_o;
   logic [CWIDTH-1:0] stall_cnt_o;
   logic [CWIDTH-1:0] flush_cnt_o;
   logic              mem_timeout_o;

   modport master (
      input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
      input  ex_rd_i, ex_is_load_i, ex_reg_we_i, br_taken_i,
      input  imem_valid_i, mem_req_i, mem_ack_i,
      output pc_en_o, f_en_o, f_flush_o, d_en_o, d_flush_o, e_en_o, m_en_o,
      output stall_cnt_o, flush_cnt_o, mem_timeout_o
   );

   modport slave (
      output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
      output ex_rd_i, ex_is_load_i, ex_reg_we_i, br_taken_i,
      output imem_valid_i, mem_req_i, mem_ack_i,
      input  pc_en_o, f_en_o, f_flush_o, d_en_o, d_flush_o, e_en_o, m_en_o,
      input  stall_cnt_o, flush_cnt_o, mem_timeout_o
   );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: sticks at all-ones, never wraps.
//   i_clk   : clock, rising edge
//   i_clear : synchronous clear (priority over i_inc)
//   i_inc   : increment request
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_clear)
         r_count <= '0;
      else if (i_inc && (r_count != {WIDTH{1'b1}}))
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline control for the 5-stage core: decides each cycle whether PC and the
// F/D, D/E, E/M, M/W registers advance, hold or take a bubble.
//   clk_i : core clock, rising edge
//   rst_i : synchronous active-low reset
//   hz    : hazard_ctrl_if.master (hazard inputs, stage enables/flushes,
//           stall/flush performance counters, sticky memory-timeout flag)
// Stage controls are combinational so they act in the cycle the hazard is seen.
// -----------------------------------------------------------------------------
module hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RWIDTH   = RWIDTH_DEF,
   parameter int CWIDTH   = CWIDTH_DEF,
   parameter int TIMEOUT  = 255,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   hazard_ctrl_if.master hz
);

   // Wait counter must hold TIMEOUT and be at least 8 bits wide.
   localparam int WCW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [WCW-1:0] TIMEOUT_W = WCW'(TIMEOUT);

   state_t            r_state;
   logic [WCW-1:0]    r_wcnt;
   logic              r_timeout;

   logic [RWIDTH-1:0] w_rs1, w_rs2, w_rd;
   logic              w_mem_busy;
   logic              w_rd_zero;
   logic              w_load_use;
   cause_t            w_cause;
   logic [WCW-1:0]    w_wcnt_inc;
   logic              w_pc_en, w_f_en, w_f_flush, w_d_en, w_d_flush, w_e_en, w_m_en;

   assign w_rs1 = hz.id_rs1_i;
   assign w_rs2 = hz.id_rs2_i;
   assign w_rd  = hz.ex_rd_i;

   // In MEM_WAIT a dropped request counts as completion, so one expression
   // covers both entering and remaining in the freeze.
   assign w_mem_busy = hz.mem_req_i & ~hz.mem_ack_i;
   assign w_rd_zero  = ZERO_REG && (w_rd == '0);
   assign w_load_use = hz.ex_is_load_i & hz.ex_reg_we_i & ~w_rd_zero &
                       ((hz.id_use_rs1_i & (w_rs1 == w_rd)) |
                        (hz.id_use_rs2_i & (w_rs2 == w_rd)));

   always_comb begin
      w_cause = CAUSE_NONE;
      if (w_mem_busy)            w_cause = CAUSE_MEM;
      else if (hz.br_taken_i)    w_cause = CAUSE_BRANCH;
      else if (w_load_use)       w_cause = CAUSE_LOAD_USE;
      else if (!hz.imem_valid_i) w_cause = CAUSE_IMEM;
   end

   always_comb begin
      w_pc_en   = 1'b1;
      w_f_en    = 1'b1;
      w_f_flush = 1'b0;
      w_d_en    = 1'b1;
      w_d_flush = 1'b0;
      w_e_en    = 1'b1;
      w_m_en    = 1'b1;
      if (!rst_i) begin
         {w_pc_en, w_f_en, w_d_en, w_e_en, w_m_en} = '0;
         w_f_flush = 1'b1;
         w_d_flush = 1'b1;
      end else begin
         unique case (w_cause)
            CAUSE_MEM: {w_pc_en, w_f_en, w_d_en, w_e_en, w_m_en} = '0;
            CAUSE_BRANCH: begin
               w_f_flush = 1'b1;
               w_d_flush = 1'b1;
            end
            // Hold PC and F/D, push one bubble into E; older work drains.
            CAUSE_LOAD_USE: begin
               w_pc_en   = 1'b0;
               w_f_en    = 1'b0;
               w_d_flush = 1'b1;
            end
            // No instruction fetched: bubble into D, keep PC.
            CAUSE_IMEM: begin
               w_pc_en   = 1'b0;
               w_f_flush = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign w_wcnt_inc = (r_wcnt == TIMEOUT_W) ? r_wcnt : r_wcnt + 1'b1;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state   <= RUN;
         r_wcnt    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_mem_busy ? MEM_WAIT : RUN;
         if (r_state == RUN) begin
            r_wcnt <= '0;
         end else if (w_mem_busy) begin
            r_wcnt <= w_wcnt_inc;
            if (w_wcnt_inc >= TIMEOUT_W)
               r_timeout <= 1'b1;
         end
      end
   end

   sat_counter #(.WIDTH(CWIDTH)) u_stall_cnt (
      .i_clk   (clk_i),
      .i_clear (~rst_i),
      .i_inc   (~w_pc_en),
      .o_count (hz.stall_cnt_o)
   );

   sat_counter #(.WIDTH(CWIDTH)) u_flush_cnt (
      .i_clk   (clk_i),
      .i_clear (~rst_i),
      .i_inc   (w_cause == CAUSE_BRANCH),
      .o_count (hz.flush_cnt_o)
   );

   assign hz.pc_en_o       = w_pc_en;
   assign hz.f_en_o        = w_f_en;
   assign hz.f_flush_o     = w_f_flush;
   assign hz.d_en_o        = w_d_en;
   assign hz.d_flush_o     = w_d_flush;
   assign hz.e_en_o        = w_e_en;
   assign hz.m_en_o        = w_m_en;
   assign hz.mem_timeout_o = r_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl built with CWIDTH=4 and TIMEOUT=8 so that
// counter saturation and the memory timeout are reachable in a few cycles.
// Inputs change 1 time unit after the rising edge; combinational controls are
// sampled 1 unit later, registered values 1 unit after the following edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   // {pc_en, f_en, f_flush, d_en, d_flush, e_en, m_en}
   localparam logic [6:0] C_NORMAL = 7'b1101011;
   localparam logic [6:0] C_FREEZE = 7'b0000000;
   localparam logic [6:0] C_RESET  = 7'b0010100;
   localparam logic [6:0] C_BRANCH = 7'b1111111;
   localparam logic [6:0] C_LDUSE  = 7'b0001111;
   localparam logic [6:0] C_IMEM   = 7'b0111011;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.RWIDTH(4), .CWIDTH(4)) bus ();

   hazard_ctrl #(
      .RWIDTH(4), .CWIDTH(4), .TIMEOUT(8), .ZERO_REG(1'b1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .hz    (bus.master)
   );

   logic [6:0] ctl;
   assign ctl = {bus.pc_en_o, bus.f_en_o, bus.f_flush_o, bus.d_en_o,
                 bus.d_flush_o, bus.e_en_o, bus.m_en_o};

   function automatic logic [6:0] exp_ctl(cause_t c);
      case (c)
         CAUSE_MEM:      return C_FREEZE;
         CAUSE_BRANCH:   return C_BRANCH;
         CAUSE_LOAD_USE: return C_LDUSE;
         CAUSE_IMEM:     return C_IMEM;
         default:        return C_NORMAL;
      endcase
   endfunction

   task automatic idle();
      bus.id_rs1_i = 4'd0;  bus.id_rs2_i = 4'd0;
      bus.id_use_rs1_i = 1'b0; bus.id_use_rs2_i = 1'b0;
      bus.ex_rd_i = 4'd0; bus.ex_is_load_i = 1'b0; bus.ex_reg_we_i = 1'b0;
      bus.br_taken_i = 1'b0; bus.imem_valid_i = 1'b1;
      bus.mem_req_i = 1'b0; bus.mem_ack_i = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         {bus.id_rs1_i, bus.id_rs2_i, bus.ex_rd_i} = 12'($urandom);
         {bus.id_use_rs1_i, bus.id_use_rs2_i, bus.ex_is_load_i, bus.ex_reg_we_i,
          bus.br_taken_i, bus.imem_valid_i, bus.mem_req_i, bus.mem_ack_i} = 8'($urandom);
         #1;
         if (ctl !== C_RESET) begin
            $display("FAIL reset_ctl[%0d]: got %b want %b", i, ctl, C_RESET); n_fail++;
         end
         n_cmp++;
         tick();
         if ({bus.stall_cnt_o, bus.flush_cnt_o, bus.mem_timeout_o} !== 9'd0) begin
            $display("FAIL reset_regs[%0d]: got stall=%0d flush=%0d to=%b want 0/0/0",
                     i, bus.stall_cnt_o, bus.flush_cnt_o, bus.mem_timeout_o); n_fail++;
         end
         n_cmp++;
      end
      rst_n = 1'b1;
      idle();
      #1;
      if (ctl !== C_NORMAL) begin
         $display("FAIL reset_release: got %b want %b", ctl, C_NORMAL); n_fail++;
      end
      n_cmp++;
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      bus.ex_is_load_i = 1'b1; bus.ex_reg_we_i = 1'b1; bus.ex_rd_i = 4'd5;
      bus.id_rs2_i = 4'd5; bus.id_use_rs2_i = 1'b1;
      #1;
      if (ctl !== exp_ctl(CAUSE_LOAD_USE)) begin
         $display("FAIL ldu_rs2: got %b want %b", ctl, C_LDUSE); n_fail++;
      end
      n_cmp++;
      tick();
      if (bus.stall_cnt_o !== 4'd1) begin
         $display("FAIL ldu_stall_cnt: got %0d want 1", bus.stall_cnt_o); n_fail++;
      end
      n_cmp++;
      // r0 as destination never hazards
      bus.ex_rd_i = 4'd0; bus.id_rs2_i = 4'd0;
      #1;
      if (ctl !== C_NORMAL) begin
         $display("FAIL ldu_r0: got %b want %b", ctl, C_NORMAL); n_fail++;
      end
      n_cmp++;
      tick();
      // rs1 path
      idle();
      bus.ex_is_load_i = 1'b1; bus.ex_reg_we_i = 1'b1; bus.ex_rd_i = 4'd3;
      bus.id_rs1_i = 4'd3; bus.id_use_rs1_i = 1'b1;
      #1;
      if (ctl !== C_LDUSE) begin
         $display("FAIL ldu_rs1: got %b want %b", ctl, C_LDUSE); n_fail++;
      end
      n_cmp++;
      tick();
      // matching index but rs1 not used
      bus.id_use_rs1_i = 1'b0;
      #1;
      if (ctl !== C_NORMAL) begin
         $display("FAIL ldu_nouse: got %b want %b", ctl, C_NORMAL); n_fail++;
      end
      n_cmp++;
      tick();
      if (bus.stall_cnt_o !== 4'd2) begin
         $display("FAIL ldu_stall_cnt2: got %0d want 2", bus.stall_cnt_o); n_fail++;
      end
      n_cmp++;
      idle();
   endtask

   task automatic test_branch_vs_load_use();
      do_reset();
      bus.ex_is_load_i = 1'b1; bus.ex_reg_we_i = 1'b1; bus.ex_rd_i = 4'd7;
      bus.id_rs1_i = 4'd7; bus.id_use_rs1_i = 1'b1;
      bus.imem_valid_i = 1'b0; bus.br_taken_i = 1'b1;
      #1;
      if (ctl !== C_BRANCH) begin
         $display("FAIL br_prio: got %b want %b", ctl, C_BRANCH); n_fail++;
      end
      n_cmp++;
      tick();
      if ({bus.flush_cnt_o, bus.stall_cnt_o} !== {4'd1, 4'd0}) begin
         $display("FAIL br_counts: got flush=%0d stall=%0d want 1/0",
                  bus.flush_cnt_o, bus.stall_cnt_o); n_fail++;
      end
      n_cmp++;
      idle();
   endtask

   task automatic test_mem_wait();
      do_reset();
      bus.mem_req_i = 1'b1; bus.mem_ack_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.br_taken_i = (i == 2);   // branch must not escape the freeze
         #1;
         if (ctl !== C_FREEZE) begin
            $display("FAIL mem_freeze[%0d]: got %b want %b", i, ctl, C_FREEZE); n_fail++;
         end
         n_cmp++;
         tick();
      end
      bus.br_taken_i = 1'b0;
      if ({bus.stall_cnt_o, bus.flush_cnt_o} !== {4'd4, 4'd0} || dut.r_state !== MEM_WAIT) begin
         $display("FAIL mem_wait_regs: got stall=%0d flush=%0d st=%0d want 4/0/1",
                  bus.stall_cnt_o, bus.flush_cnt_o, dut.r_state); n_fail++;
      end
      n_cmp++;
      bus.mem_ack_i = 1'b1;
      #1;
      if (ctl !== C_NORMAL) begin
         $display("FAIL mem_ack: got %b want %b", ctl, C_NORMAL); n_fail++;
      end
      n_cmp++;
      tick();
      if (dut.r_state !== RUN || bus.stall_cnt_o !== 4'd4) begin
         $display("FAIL mem_release: got st=%0d stall=%0d want 0/4",
                  dut.r_state, bus.stall_cnt_o); n_fail++;
      end
      n_cmp++;
      // request dropped without ack in MEM_WAIT acts as completion
      bus.mem_ack_i = 1'b0;
      tick();
      bus.mem_req_i = 1'b0;
      #1;
      if (ctl !== C_NORMAL) begin
         $display("FAIL mem_drop: got %b want %b", ctl, C_NORMAL); n_fail++;
      end
      n_cmp++;
      tick();
      if (dut.r_state !== RUN) begin
         $display("FAIL mem_drop_state: got %0d want 0", dut.r_state); n_fail++;
      end
      n_cmp++;
      idle();
   endtask

   task automatic test_timeout();
      do_reset();
      bus.mem_req_i = 1'b1; bus.mem_ack_i = 1'b0;
      // cycle 0 is in RUN; cycles 1..11 are MEM_WAIT cycles
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.mem_timeout_o !== (k >= 8)) begin
            $display("FAIL timeout[%0d]: got %b want %b", k, bus.mem_timeout_o, (k >= 8)); n_fail++;
         end
         n_cmp++;
      end
      bus.mem_ack_i = 1'b1;
      #1;
      if (ctl !== C_NORMAL) begin
         $display("FAIL timeout_ack: got %b want %b", ctl, C_NORMAL); n_fail++;
      end
      n_cmp++;
      tick();
      idle();
      tick();
      if (bus.mem_timeout_o !== 1'b1) begin
         $display("FAIL timeout_sticky: got %b want 1", bus.mem_timeout_o); n_fail++;
      end
      n_cmp++;
      do_reset();
      if (bus.mem_timeout_o !== 1'b0) begin
         $display("FAIL timeout_clear: got %b want 0", bus.mem_timeout_o); n_fail++;
      end
      n_cmp++;
   endtask

   task automatic test_saturation();
      do_reset();
      bus.imem_valid_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (ctl !== C_IMEM) begin
            $display("FAIL sat_ctl[%0d]: got %b want %b", i, ctl, C_IMEM); n_fail++;
         end
         n_cmp++;
         tick();
         if (bus.stall_cnt_o !== ((i + 1 > 15) ? 4'd15 : 4'(i + 1))) begin
            $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bus.stall_cnt_o,
                     (i + 1 > 15) ? 15 : i + 1); n_fail++;
         end
         n_cmp++;
      end
      idle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      // load-use, then branch, then imem stall on consecutive cycles
      bus.ex_is_load_i = 1'b1; bus.ex_reg_we_i = 1'b1; bus.ex_rd_i = 4'd9;
      bus.id_rs2_i = 4'd9; bus.id_use_rs2_i = 1'b1;
      #1;
      if (ctl !== C_LDUSE) begin
         $display("FAIL b2b_ldu: got %b want %b", ctl, C_LDUSE); n_fail++;
      end
      n_cmp++;
      tick();
      idle(); bus.br_taken_i = 1'b1;
      #1;
      if (ctl !== C_BRANCH) begin
         $display("FAIL b2b_br: got %b want %b", ctl, C_BRANCH); n_fail++;
      end
      n_cmp++;
      tick();
      idle(); bus.imem_valid_i = 1'b0;
      #1;
      if (ctl !== C_IMEM) begin
         $display("FAIL b2b_imem: got %b want %b", ctl, C_IMEM); n_fail++;
      end
      n_cmp++;
      tick();
      if ({bus.stall_cnt_o, bus.flush_cnt_o} !== {4'd2, 4'd1}) begin
         $display("FAIL b2b_counts: got stall=%0d flush=%0d want 2/1",
                  bus.stall_cnt_o, bus.flush_cnt_o); n_fail++;
      end
      n_cmp++;
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #1;
      test_reset();
      test_load_use();
      test_branch_vs_load_use();
      test_mem_wait();
      test_timeout();
      test_saturation();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
